// File: rtl/tpu_sched_pkg.sv
// Shared types and constants for the TPU job scheduler: FSM states, completion
// status codes and the layout of the packed {m,k,n} dims field.
package tpu_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLaunch,
        StRun,
        StRetire
    } sched_state_e;

    localparam logic [1:0] STAT_OK      = 2'd0;
    localparam logic [1:0] STAT_TIMEOUT = 2'd1;
    localparam logic [1:0] STAT_BADDIM  = 2'd2;

    localparam int unsigned DIMS_W    = 12;
    localparam int unsigned DIM_FW    = 4;
    localparam int unsigned DIM_M_LSB = 8;
    localparam int unsigned DIM_K_LSB = 4;
    localparam int unsigned DIM_N_LSB = 0;

    // Largest k the core's 12-entry skew buffer can absorb.
    localparam int unsigned SKEW_MAX_K = 8;

    function automatic logic dims_bad(input logic [DIMS_W-1:0] dims, input int unsigned max_k);
        logic [DIM_FW-1:0] m, k, n;
        m = dims[DIM_M_LSB +: DIM_FW];
        k = dims[DIM_K_LSB +: DIM_FW];
        n = dims[DIM_N_LSB +: DIM_FW];
        return (m == '0) || (k == '0) || (n == '0) || (32'(k) > max_k);
    endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// Small synchronous descriptor FIFO; pointers carry an extra wrap bit so full
// and empty can be told apart without a separate count.
module sched_job_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/tpu_job_sched.sv
// Job scheduler for the 4x4 systolic core: queues descriptors, sequences
// clear/start/run per job, enforces a run timeout and relocates buffer indices.
module tpu_job_sched
    import tpu_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned QDEPTH     = 2,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned MAX_K      = SKEW_MAX_K,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned CYC_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ID_W-1:0]   job_id,
    input  logic [DIMS_W-1:0] job_dims,
    input  logic [ADDR_W-1:0] job_base_a,
    input  logic [ADDR_W-1:0] job_base_b,
    input  logic [ADDR_W-1:0] job_base_o,
    output logic              core_rst,
    output logic              core_start,
    output logic [DIMS_W-1:0] core_dims,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] core_index_a,
    input  logic [ADDR_W-1:0] core_index_b,
    input  logic [ADDR_W-1:0] core_index_o,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [ID_W-1:0]   cpl_id,
    output logic [1:0]        cpl_status,
    output logic [CYC_W-1:0]  cpl_cycles,
    output logic              busy
);

    localparam int unsigned DESC_W = ID_W + DIMS_W + 3 * ADDR_W;
    localparam int unsigned CLR_W  = $clog2(CLR_CYCLES + 1);

    sched_state_e      state;
    logic [CLR_W-1:0]  clr_cnt;
    logic [CYC_W-1:0]  run_cnt;
    logic [ADDR_W-1:0] base_a, base_b, base_o;

    logic [DESC_W-1:0] q_wdata, q_rdata;
    logic              q_full, q_empty, q_pop;
    logic [ID_W-1:0]   q_id;
    logic [DIMS_W-1:0] q_dims;
    logic [ADDR_W-1:0] q_base_a, q_base_b, q_base_o;

    assign q_wdata   = {job_id, job_dims, job_base_a, job_base_b, job_base_o};
    assign {q_id, q_dims, q_base_a, q_base_b, q_base_o} = q_rdata;
    assign q_pop     = (state == StIdle) && !q_empty;
    assign job_ready = !q_full;
    assign busy      = (state != StIdle) || !q_empty;

    assign mem_addr_a = base_a + core_index_a;
    assign mem_addr_b = base_b + core_index_b;
    assign mem_addr_o = base_o + core_index_o;

    sched_job_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (job_valid && job_ready),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            clr_cnt    <= '0;
            run_cnt    <= '0;
            base_a     <= '0;
            base_b     <= '0;
            base_o     <= '0;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
            core_dims  <= '0;
            cpl_valid  <= 1'b0;
            cpl_id     <= '0;
            cpl_status <= STAT_OK;
            cpl_cycles <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    core_rst <= 1'b0;
                    if (!q_empty) begin
                        core_dims <= q_dims;
                        base_a    <= q_base_a;
                        base_b    <= q_base_b;
                        base_o    <= q_base_o;
                        cpl_id    <= q_id;
                        if (dims_bad(q_dims, MAX_K)) begin
                            state      <= StRetire;
                            cpl_valid  <= 1'b1;
                            cpl_status <= STAT_BADDIM;
                            cpl_cycles <= '0;
                        end else begin
                            state    <= StClear;
                            core_rst <= 1'b1;
                            clr_cnt  <= '0;
                        end
                    end
                end
                StClear: begin
                    if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        state      <= StLaunch;
                        core_rst   <= 1'b0;
                        core_start <= 1'b1;
                        run_cnt    <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                StLaunch: begin
                    core_start <= 1'b0;
                    state      <= StRun;
                end
                StRun: begin
                    // done wins over a coincident timeout; the done cycle is counted
                    if (core_done) begin
                        state      <= StRetire;
                        cpl_valid  <= 1'b1;
                        cpl_status <= STAT_OK;
                        cpl_cycles <= run_cnt + CYC_W'(1);
                    end else if (run_cnt == CYC_W'(TIMEOUT - 1)) begin
                        state      <= StRetire;
                        cpl_valid  <= 1'b1;
                        cpl_status <= STAT_TIMEOUT;
                        cpl_cycles <= CYC_W'(TIMEOUT);
                    end else begin
                        run_cnt <= run_cnt + CYC_W'(1);
                    end
                end
                StRetire: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_job_sched.sv
// Randomized bench for tpu_job_sched: a transaction-level scoreboard plus a
// sticky-done core model predict completions, launch spacing and addresses.
module tb_tpu_job_sched;

    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned QDEPTH     = 2;
    localparam int unsigned CLR_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 1024;
    localparam int unsigned MAX_K      = 8;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned CYC_W      = 16;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [11:0]       dims;
        logic [ADDR_W-1:0] ba;
        logic [ADDR_W-1:0] bb;
        logic [ADDR_W-1:0] bo;
        int unsigned       lat;
    } job_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid;
    logic              job_ready;
    logic [ID_W-1:0]   job_id;
    logic [11:0]       job_dims;
    logic [ADDR_W-1:0] job_base_a, job_base_b, job_base_o;
    logic              core_rst, core_start;
    logic [11:0]       core_dims;
    logic              core_done;
    logic [ADDR_W-1:0] core_index_a, core_index_b, core_index_o;
    logic [ADDR_W-1:0] mem_addr_a, mem_addr_b, mem_addr_o;
    logic              cpl_valid, cpl_ready;
    logic [ID_W-1:0]   cpl_id;
    logic [1:0]        cpl_status;
    logic [CYC_W-1:0]  cpl_cycles;
    logic              busy;

    tpu_job_sched #(
        .ADDR_W     (ADDR_W),
        .QDEPTH     (QDEPTH),
        .CLR_CYCLES (CLR_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .MAX_K      (MAX_K),
        .ID_W       (ID_W),
        .CYC_W      (CYC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_id       (job_id),
        .job_dims     (job_dims),
        .job_base_a   (job_base_a),
        .job_base_b   (job_base_b),
        .job_base_o   (job_base_o),
        .core_rst     (core_rst),
        .core_start   (core_start),
        .core_dims    (core_dims),
        .core_done    (core_done),
        .core_index_a (core_index_a),
        .core_index_b (core_index_b),
        .core_index_o (core_index_o),
        .mem_addr_a   (mem_addr_a),
        .mem_addr_b   (mem_addr_b),
        .mem_addr_o   (mem_addr_o),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_id       (cpl_id),
        .cpl_status   (cpl_status),
        .cpl_cycles   (cpl_cycles),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fails  = 0;
    job_t exp_q[$];
    job_t core_q[$];
    job_t cur_job;
    bit   in_core = 0;
    bit   hs_prev = 0;
    int   core_cnt = 0;
    int   core_lat = 0;
    int   rst_run = 0;
    int   starts = 0;
    int   good_jobs = 0;
    int   hs_count = 0;
    int   rdy_mode = 0;
    bit   idx_fixed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [11:0] d);
        int m, k, n;
        logic [11:0] v;
        v = d;
        m = int'(v[11:8]);
        k = int'(v[7:4]);
        n = int'(v[3:0]);
        return (m == 0) || (k == 0) || (n == 0) || (k > int'(MAX_K));
    endfunction

    function automatic int exp_status(input job_t j);
        if (is_bad(j.dims)) return 2;
        return (j.lat <= TIMEOUT) ? 0 : 1;
    endfunction

    function automatic int exp_cycles(input job_t j);
        if (is_bad(j.dims)) return 0;
        return (j.lat <= TIMEOUT) ? int'(j.lat) : int'(TIMEOUT);
    endfunction

    // Index and completion-ready drivers, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!idx_fixed) begin
            core_index_a = ADDR_W'($urandom);
            core_index_b = ADDR_W'($urandom);
            core_index_o = ADDR_W'($urandom);
        end
        case (rdy_mode)
            0:       cpl_ready = 1'b1;
            1:       cpl_ready = ($urandom_range(0, 3) != 0);
            default: cpl_ready = 1'b0;
        endcase
    end

    // Monitor and core model, evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            core_cnt  = 0;
            core_done = 1'b0;
            rst_run   = 0;
            hs_prev   = 0;
        end else begin
            if (hs_prev) check_eq("cpl_valid_drop", cpl_valid, 0);
            hs_prev = 0;
            if (core_start) begin
                starts++;
                check_eq("clear_len_before_start", rst_run, CLR_CYCLES);
                check_eq("start_while_cpl", cpl_valid, 0);
                check_eq("start_has_job", core_q.size() > 0, 1);
                if (core_q.size() > 0) begin
                    cur_job = core_q.pop_front();
                    in_core = 1;
                    check_eq("core_dims", core_dims, cur_job.dims);
                end
            end
            rst_run = core_rst ? rst_run + 1 : 0;
            if (in_core) begin
                check_eq("mem_addr_a", mem_addr_a, (int'(cur_job.ba) + int'(core_index_a)) % 512);
                check_eq("mem_addr_b", mem_addr_b, (int'(cur_job.bb) + int'(core_index_b)) % 512);
                check_eq("mem_addr_o", mem_addr_o, (int'(cur_job.bo) + int'(core_index_o)) % 512);
            end
            if (cpl_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("cpl_unexpected", cpl_valid, 0);
                end else begin
                    check_eq("cpl_id", cpl_id, exp_q[0].id);
                    check_eq("cpl_status", cpl_status, exp_status(exp_q[0]));
                    check_eq("cpl_cycles", cpl_cycles, exp_cycles(exp_q[0]));
                    if (cpl_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        in_core = 0;
                        hs_prev = 1;
                    end
                end
            end
            // Core: done is sticky and rises `lat` cycles after the start pulse.
            if (core_rst) begin
                core_cnt = 0;
            end else if (core_start) begin
                core_cnt = 1;
                core_lat = int'(cur_job.lat);
            end else if (core_cnt > 0) begin
                core_cnt++;
            end
            core_done = (core_cnt > 0) && (core_cnt > core_lat);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_job(input job_t j);
        int waited = 0;
        job_valid  = 1'b1;
        job_id     = j.id;
        job_dims   = j.dims;
        job_base_a = j.ba;
        job_base_b = j.bb;
        job_base_o = j.bo;
        forever begin
            @(negedge clk);
            if (job_ready) break;
            waited++;
            if (waited > 5000) begin
                check_eq("push_accepted", job_ready, 1);
                break;
            end
        end
        if (job_ready) begin
            exp_q.push_back(j);
            if (!is_bad(j.dims)) begin
                core_q.push_back(j);
                good_jobs++;
            end
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    function automatic job_t mk(input int id, input logic [11:0] d, input int unsigned lat);
        job_t j;
        j.id   = ID_W'(id);
        j.dims = d;
        j.ba   = ADDR_W'($urandom);
        j.bb   = ADDR_W'($urandom);
        j.bo   = ADDR_W'($urandom);
        j.lat  = lat;
        return j;
    endfunction

    task automatic wait_starts(input int target);
        int t = 0;
        while (starts < target && t < 3000) begin
            step(1);
            t++;
        end
        check_eq("start_seen", starts >= target, 1);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < budget) begin
            step(1);
            t++;
        end
        check_eq("drain_busy", busy, 0);
        check_eq("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        job_t j;
        int h0, s0, t;
        rst_n      = 1'b0;
        job_valid  = 1'b0;
        job_id     = '0;
        job_dims   = '0;
        job_base_a = '0;
        job_base_b = '0;
        job_base_o = '0;
        core_done  = 1'b0;
        cpl_ready  = 1'b1;
        core_index_a = '0;
        core_index_b = '0;
        core_index_o = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_core_rst", core_rst, 1);
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_core_dims", core_dims, 0);
        check_eq("rst_cpl_valid", cpl_valid, 0);
        check_eq("rst_cpl_id", cpl_id, 0);
        check_eq("rst_cpl_status", cpl_status, 0);
        check_eq("rst_cpl_cycles", cpl_cycles, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_base_a", mem_addr_a, core_index_a);
        rst_n = 1'b1;
        step(1);
        check_eq("idle_job_ready", job_ready, 1);
        check_eq("idle_core_rst", core_rst, 0);

        // Basic job
        push_job(mk(3, 12'h444, 20));
        drain(500);

        // Bad dims, then a good job
        push_job(mk(5, 12'h494, 5));
        push_job(mk(6, 12'h044, 5));
        push_job(mk(7, 12'h321, 9));
        drain(500);

        // Timeout, recovery, and done coinciding with timeout
        push_job(mk(8, 12'h222, 5000));
        push_job(mk(9, 12'h111, 12));
        drain(4000);
        push_job(mk(10, 12'h181, TIMEOUT));
        drain(4000);

        // Queueing behind a long job
        push_job(mk(1, 12'h333, 300));
        wait_starts(starts + 1);
        push_job(mk(2, 12'h212, 5));
        push_job(mk(4, 12'h121, 5));
        check_eq("full_job_ready", job_ready, 0);
        h0 = hs_count;
        push_job(mk(11, 12'h515, 5));
        check_eq("third_after_first_pop", hs_count > h0, 1);
        drain(2000);

        // Completion backpressure with a second job queued
        rdy_mode = 2;
        s0 = starts;
        push_job(mk(12, 12'h282, 10));
        push_job(mk(13, 12'h111, 4));
        t = 0;
        while (!cpl_valid && t < 500) begin
            step(1);
            t++;
        end
        check_eq("bp_cpl_seen", cpl_valid, 1);
        step(5);
        check_eq("bp_no_second_start", starts, s0 + 1);
        rdy_mode = 0;
        drain(500);

        // Random traffic
        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            logic [11:0] d;
            if ($urandom_range(0, 4) == 0) d = 12'($urandom);
            else d = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 8)), 4'($urandom_range(1, 15))};
            push_job(mk(i, d, $urandom_range(1, 40)));
            step($urandom_range(0, 3));
        end
        drain(20000);
        rdy_mode = 0;

        // Address wrap, then reset during RUN
        idx_fixed = 1;
        core_index_a = 9'h020;
        j = mk(14, 12'h444, 5000);
        j.ba = 9'h1F0;
        push_job(j);
        push_job(mk(15, 12'h111, 3));
        wait_starts(starts + 1);
        step(3);
        check_eq("addr_wrap", mem_addr_a, 9'h010);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_core_rst", core_rst, 1);
        check_eq("midrst_core_start", core_start, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_cpl_valid", cpl_valid, 0);
        check_eq("midrst_job_ready", job_ready, 1);
        good_jobs -= core_q.size();
        core_q.delete();
        exp_q.delete();
        in_core = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idx_fixed = 0;
        step(20);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_no_cpl", cpl_valid, 0);
        push_job(mk(9, 12'h232, 6));
        drain(500);

        check_eq("start_total", starts, good_jobs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tpu_job_sched.md
Name: tpu_job_sched

Overview:
- Job scheduler and sequencer for the 4x4 systolic tpu core.
- Accepts matrix-multiply job descriptors from the host into a small queue.
- Per job: validates dims, holds the core in a clean reset, pulses start, waits for done (with timeout), and reports a completion record.
- Relocates the core's buffer indices by per-job base addresses, so several jobs can share one set of A/B/O buffers.

Parameters:
- ADDR_W, 9: buffer address width; equals the codebase DATA_SIZE.
- QDEPTH, 2: descriptor queue depth; power of 2, at least 2.
- CLR_CYCLES, 2: number of cycles core_rst is held per job.
- TIMEOUT, 1024: maximum RUN cycles before a job is aborted.
- MAX_K, 8: largest legal k, set by the core's 12-entry skew buffer.
- ID_W, 4 / CYC_W, 16: job-id width / cycle-count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- job_valid  in  1  descriptor valid.
- job_ready  out  1  queue not full.
- job_id  in  ID_W  tag echoed in the completion.
- job_dims  in  12  {m[11:8], k[7:4], n[3:0]}.
- job_base_a  in  ADDR_W  base of A buffer region.
- job_base_b  in  ADDR_W  base of B buffer region.
- job_base_o  in  ADDR_W  base of output region.
- core_rst  out  1  active-high reset to the core.
- core_start  out  1  one-cycle start pulse to the core.
- core_dims  out  12  {m,k,n} to the core; stable from CLEAR through RUN.
- core_done  in  1  core done (sticky until core reset).
- core_index_a  in  ADDR_W  core A index.
- core_index_b  in  ADDR_W  core B index.
- core_index_o  in  ADDR_W  core output index.
- mem_addr_a  out  ADDR_W  base_a + core_index_a.
- mem_addr_b  out  ADDR_W  base_b + core_index_b.
- mem_addr_o  out  ADDR_W  base_o + core_index_o.
- cpl_valid  out  1  completion valid.
- cpl_ready  in  1  completion accepted.
- cpl_id  out  ID_W  job tag.
- cpl_status  out  2  0=OK, 1=TIMEOUT, 2=BADDIM.
- cpl_cycles  out  CYC_W  RUN cycles consumed.
- busy  out  1  state!=IDLE or queue non-empty.

Behaviour:
- Reset values (asynchronous while rst_n=0):
  - state=IDLE, queue empty.
  - core_rst=1, core_start=0, core_dims=0, bases=0.
  - cpl_valid=0, cpl_id=0, cpl_status=0, cpl_cycles=0, busy=0.
  - job_ready=1 after release.
- Queue:
  - Push on job_valid & job_ready; job_ready = !full.
  - A pushed entry is visible to the FSM the next cycle; no same-cycle bypass.
  - Pointers wrap modulo QDEPTH.
  - When full, job_ready=0 and descriptors are not dropped; the host holds them.
- FSM, all outputs registered:
  - IDLE: core_rst=0. If the queue is non-empty, latch the head into active regs and pop. If m==0, n==0, k==0 or k>MAX_K, go to RETIRE with status=2, cycles=0, and core_start never pulses. Otherwise go to CLEAR.
  - CLEAR: core_rst=1 for exactly CLR_CYCLES cycles, then LAUNCH.
  - LAUNCH: core_rst=0, core_start=1 for exactly one cycle, cycle counter cleared to 0, then RUN.
  - RUN: counter increments each cycle. If core_done=1, go to RETIRE with status=0 and cycles = counter+1, counting the done cycle. Else, if counter==TIMEOUT-1, go to RETIRE with status=1 and cycles=TIMEOUT. core_done is ignored outside RUN.
  - RETIRE: cpl_valid=1; cpl_id, cpl_status and cpl_cycles held stable until cpl_ready=1. On handshake, cpl_valid=0 the next cycle and the FSM returns to IDLE. The next launch is no earlier than that IDLE cycle.
- Core state: the sticky core done and any timed-out core state are always cleared by the next job's CLEAR. No cleanup is done at RETIRE.
- Addresses: mem_addr_* are combinational adds of the latched base and the core index, truncated to ADDR_W (wrap modulo 2^ADDR_W). They remain valid from CLEAR until the next IDLE pop.
- Simultaneous events:
  - A push during an IDLE pop is legal when not full.
  - A core_done and timeout in the same cycle resolves as OK.
- Reset mid-operation: rst_n low in any state abandons the active job, empties the queue, emits no completion, and asserts core_rst immediately.

Decomposition:
- Package tpu_sched_pkg holds:
  - the FSM state encoding (IDLE, CLEAR, LAUNCH, RUN, RETIRE);
  - status codes STAT_OK, STAT_TIMEOUT, STAT_BADDIM;
  - dims field offsets and the MAX_K constant.
- One sub-module: sched_job_fifo, a synchronous QDEPTH-entry FIFO with full/empty flags and the same rst_n.

Test Plan:
- Basic job: push dims m=4,k=4,n=4, id=3; core model raises done 20 cycles after start.
  -> core_rst high for exactly 2 cycles, one core_start pulse, completion {id=3, status=0, cycles=20}.
- Queueing: push 3 jobs back-to-back with a stalled core.
  -> job_ready=0 after the 2nd push; 3rd accepted only after the first pop; completions in push order with ids matching.
- Bad dims: k=9, then m=0.
  -> status=2, cycles=0, core_start never asserted; next valid job launches normally.
- Timeout and recovery: done never asserts.
  -> status=1, cycles=1024; following job gets a full CLEAR and completes OK.
- Backpressure: cpl_ready held low 5 cycles with a second job queued.
  -> cpl fields stable; no core_start until the cycle after the handshake.
- Address wrap and mid-run reset: base_a=0x1F0 with index 0x020.
  -> mem_addr_a=0x010. Then drop rst_n during RUN -> core_rst=1 at once, queue empty, busy=0, no cpl.
